// File: rtl/mult_pkg.sv
// Shared types and constants for the EX-stage multiply sequencing controller.
package mult_pkg;

    localparam int DATA_W = 32;
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        CAPTURE
    } state_t;

endpackage

// File: rtl/mult_lat_counter.sv
// Latency counter for the multiply controller: loadable up-counter with a
// terminal-count flag raised when the count equals MULT_LAT-1.
module mult_lat_counter
    import mult_pkg::*;
#(
    parameter int MULT_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(MULT_LAT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/mult_ctrl.sv
// Sequencing controller for the shared signed multiplier with HI/LO interlock.
// Optional macro MULT_FASTZERO_EN: zero operands bypass the multiplier.
module mult_ctrl #(
    parameter int DATA_W   = mult_pkg::DATA_W,
    parameter int MULT_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_W-1:0]     req_a,
    input  logic [DATA_W-1:0]     req_b,
    input  logic                  flush,
    input  logic                  rd_hi,
    input  logic                  rd_lo,
    output logic                  stall,
    output logic                  mult_en,
    output logic [DATA_W-1:0]     mult_a,
    output logic [DATA_W-1:0]     mult_b,
    input  logic [2*DATA_W-1:0]   mult_result,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo,
    output logic                  done
);

    import mult_pkg::*;

    state_t            state;
    state_t            state_n;
    logic              accept;
    logic              capture;
    logic              cnt_clear;
    logic              lat_tc;
    logic [DATA_W-1:0] cap_hi;
    logic [DATA_W-1:0] cap_lo;

    assign req_ready = (state == IDLE);
    assign mult_en   = (state == BUSY);
    assign stall     = (state != IDLE) && (rd_hi || rd_lo);
    assign accept    = (state == IDLE) && req_valid && !flush;
    assign cnt_clear = (state != IDLE) && (state_n == IDLE);

`ifdef MULT_FASTZERO_EN
    // A zero operand goes straight to the capture cycle with a forced-zero
    // product, so the multiplier is never enabled for it.
    logic zero_op;
    logic zero_pend;

    assign zero_op = (req_a == '0) || (req_b == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_pend <= 1'b0;
        end else if (accept) begin
            zero_pend <= zero_op;
        end
    end

    assign cap_hi = zero_pend ? '0 : mult_result[2*DATA_W-1:DATA_W];
    assign cap_lo = zero_pend ? '0 : mult_result[DATA_W-1:0];
`else
    assign cap_hi = mult_result[2*DATA_W-1:DATA_W];
    assign cap_lo = mult_result[DATA_W-1:0];
`endif

    always_comb begin
        state_n = state;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MULT_FASTZERO_EN
                    state_n = zero_op ? CAPTURE : BUSY;
`else
                    state_n = BUSY;
`endif
                end
            end
            BUSY: begin
                if (flush) begin
                    state_n = IDLE;
                end else if (lat_tc) begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                state_n = IDLE;
                capture = !flush;
            end
            default: state_n = IDLE;
        endcase
    end

    mult_lat_counter #(
        .MULT_LAT (MULT_LAT)
    ) u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .load     (accept),
        .load_val ('0),
        .en       (mult_en),
        .tc       (lat_tc)
    );

    // Operands stay frozen from accept until the next accept so the
    // multiplier sees stable inputs for the whole BUSY window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mult_a <= '0;
            mult_b <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_n;
            done  <= capture;
            if (accept) begin
                mult_a <= req_a;
                mult_b <= req_b;
            end
            if (capture) begin
                hi <= cap_hi;
                lo <= cap_lo;
            end
        end
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// Scoreboard bench for mult_ctrl: cycle-count reference model, attached
// multiplier model, and a done-driven monitor checking HI/LO and timing.
module tb_mult_ctrl;

    localparam int DW  = 32;
    localparam int LAT = 3;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic          flush;
    logic          rd_hi;
    logic          rd_lo;
    logic          stall;
    logic          mult_en;
    logic [DW-1:0] mult_a;
    logic [DW-1:0] mult_b;
    logic [2*DW-1:0] mult_result;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          done;

    exp_t        scoreboard[$];
    exp_t        got;
    int          checks;
    int          errors;
    int          cyc;
    int          busy_left;
    bit          accepted;
    logic [31:0] cur_a;
    logic [31:0] cur_b;
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;
    logic [63:0] pend_prod;
    logic [63:0] mul_pipe [LAT];

    always #5 clk = ~clk;

    mult_ctrl #(
        .DATA_W   (DW),
        .MULT_LAT (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .flush       (flush),
        .rd_hi       (rd_hi),
        .rd_lo       (rd_lo),
        .stall       (stall),
        .mult_en     (mult_en),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_result (mult_result),
        .hi          (hi),
        .lo          (lo),
        .done        (done)
    );

    function automatic logic [63:0] ref_mult(logic [31:0] a, logic [31:0] b);
        longint sa;
        longint sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    function automatic int eff_lat(logic [31:0] a, logic [31:0] b);
`ifdef MULT_FASTZERO_EN
        if (a == 0 || b == 0) return 0;
`endif
        return LAT;
    endfunction

    function void chk(string name, logic [63:0] act, logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp_v, cyc);
        end
    endfunction

    // Attached multiplier: LAT-stage pipeline of the signed product.
    always @(posedge clk) begin
        mul_pipe[0] <= ref_mult(mult_a, mult_b);
        for (int i = 1; i < LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    assign mult_result = mul_pipe[LAT-1];

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (scoreboard.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done actual=1 expected=0 cycle=%0d", cyc);
            end else begin
                got = scoreboard.pop_front();
                chk("done_hi", hi, got.prod[63:32]);
                chk("done_lo", lo, got.prod[31:0]);
                chk("done_cycle", cyc, got.due);
            end
        end
    end

    task automatic check_output();
        chk("req_ready", req_ready, busy_left == 0);
        chk("mult_en", mult_en, busy_left > 1);
        chk("stall", stall, (busy_left > 0) && (rd_hi || rd_lo));
        chk("mult_a", mult_a, cur_a);
        chk("mult_b", mult_b, cur_b);
        chk("hi", hi, mdl_hi);
        chk("lo", lo, mdl_lo);
    endtask

    // Reference model: an op occupies the unit for its latency plus one
    // capture cycle; HI/LO take the product when that window closes.
    task automatic model_edge();
        int lat;
        cyc++;
        accepted = 1'b0;
        if (reset) begin
            busy_left = 0;
            cur_a = 0;
            cur_b = 0;
            mdl_hi = 0;
            mdl_lo = 0;
            scoreboard.delete();
        end else if (busy_left > 0) begin
            if (flush) begin
                busy_left = 0;
                if (scoreboard.size() > 0) scoreboard.delete(scoreboard.size() - 1);
            end else begin
                busy_left--;
                if (busy_left == 0) {mdl_hi, mdl_lo} = pend_prod;
            end
        end else if (req_valid && !flush) begin
            lat = eff_lat(req_a, req_b);
            busy_left = lat + 1;
            cur_a = req_a;
            cur_b = req_b;
            pend_prod = ref_mult(req_a, req_b);
            scoreboard.push_back('{prod: pend_prod, due: cyc + lat + 1});
            accepted = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_output();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic start_req(logic [31:0] a, logic [31:0] b);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        accepted = 1'b0;
        while (!accepted && n < 64) begin
            tick();
            n++;
        end
        req_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=not_accepted expected=accepted a=%h b=%h", a, b);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_left > 0 && n < 64) begin
            tick();
            n++;
        end
        if (busy_left > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout actual=busy expected=idle");
        end
    endtask

    task automatic issue(logic [31:0] a, logic [31:0] b);
        start_req(a, b);
        wait_idle();
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] edges [4];
        edges[0] = 32'h8000_0000;
        edges[1] = 32'h7fff_ffff;
        edges[2] = 32'hffff_ffff;
        edges[3] = 32'h0000_0001;
        case ($urandom_range(0, 4))
            0:       return 32'($urandom_range(0, 255)) - 32'd128;
            1:       return 32'h0;
            2:       return edges[$urandom_range(0, 3)];
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        flush = 1'b0;
        rd_hi = 1'b1;
        rd_lo = 1'b0;

        repeat (2) tick();
        reset = 1'b0;
        rd_hi = 1'b0;
        tick();

        issue(2, 1);
        repeat (2) tick();
        issue(-7, 3);
        issue(-2, -2);
        issue(20, -10);

        // HI read interlock with a second request held during BUSY
        start_req(19, 3);
        rd_hi = 1'b1;
        start_req(4, 5);
        rd_hi = 1'b0;
        wait_idle();

        issue(5, 2);
        start_req(2, -125);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();

        start_req(3, 3);
        repeat (LAT) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();

        req_valid = 1'b1;
        req_a = 9;
        req_b = 9;
        flush = 1'b1;
        tick();
        req_valid = 1'b0;
        flush = 1'b0;
        tick();

        issue(5, 2);
        start_req(7, 7);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        issue(2, 5);

        issue(0, -60);
        issue(123, 0);

        for (int i = 0; i < 60; i++) begin
            rd_hi = 1'($urandom_range(0, 1));
            rd_lo = 1'($urandom_range(0, 1));
            start_req(rand_operand(), rand_operand());
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(0, LAT)) tick();
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(0, 2)) tick();
        end
        rd_hi = 1'b0;
        rd_lo = 1'b0;

        repeat (3) tick();
        chk("scoreboard_empty", 64'(scoreboard.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
